// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops plus an
// iterative shift-add unsigned multiplier that takes WIDTH cycles.
module seq_alu #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [3:0]       i_sel,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result,
   output logic             o_c,
   output logic             o_z
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [3:0] OpMul = 4'd15;

   typedef enum logic {StIdle, StMul} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_result;
   logic               r_c;
   logic               r_z;
   logic               r_done;

   logic               w_accept;
   logic               w_mul_last;
   logic [WIDTH:0]     w_ext_a;
   logic [WIDTH:0]     w_ext_b;
   logic [WIDTH:0]     w_ext_cin;
   logic [WIDTH-1:0]   w_val;
   logic               w_c;
   logic               w_z;
   logic               w_wr_res;
   logic               w_wr_flags;
   logic [2*WIDTH-1:0] w_addend;
   logic [2*WIDTH-1:0] w_acc_next;

   assign w_accept   = i_start && (r_state == StIdle);
   assign w_mul_last = (r_state == StMul) && (r_cnt == CW'(WIDTH - 1));

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: only MUL leaves IDLE
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: if (w_accept && (i_sel == OpMul)) w_state_next = StMul;
         StMul:  if (w_mul_last) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      o_busy = (r_state == StMul);
   end

   // Single-cycle operation result, flags and write enables from live inputs
   always_comb begin
      w_ext_a    = {1'b0, i_a};
      w_ext_b    = {1'b0, i_b};
      w_ext_cin  = {{WIDTH{1'b0}}, i_cin};
      w_val      = '0;
      w_c        = 1'b0;
      w_wr_res   = 1'b1;
      w_wr_flags = 1'b1;
      case (i_sel)
         4'd0:  {w_c, w_val} = w_ext_a + w_ext_b;
         4'd1:  {w_c, w_val} = w_ext_a + w_ext_b + w_ext_cin;
         4'd2:  {w_c, w_val} = w_ext_a - w_ext_b;
         4'd3:  {w_c, w_val} = w_ext_a - w_ext_b - w_ext_cin;
         4'd4: begin
            {w_c, w_val} = w_ext_a - w_ext_b;
            w_wr_res     = 1'b0;
         end
         4'd5:  w_val = i_a & i_b;
         4'd6:  w_val = i_a | i_b;
         4'd7:  w_val = i_a ^ i_b;
         4'd8: begin
            w_val    = i_a & i_b;
            w_wr_res = 1'b0;
         end
         4'd9: begin
            w_val = {i_a[WIDTH-2:0], i_cin};
            w_c   = i_a[WIDTH-1];
         end
         4'd10: begin
            w_val = {i_cin, i_a[WIDTH-1:1]};
            w_c   = i_a[0];
         end
         4'd11: begin
            w_val = {i_a[WIDTH-2:0], i_a[WIDTH-1]};
            w_c   = i_a[WIDTH-1];
         end
         4'd12: begin
            w_val = {i_a[0], i_a[WIDTH-1:1]};
            w_c   = i_a[0];
         end
         4'd13: begin
            w_val = {i_a[WIDTH-1], i_a[WIDTH-1:1]};
            w_c   = i_a[0];
         end
         4'd14: begin
            w_val      = i_b;
            w_wr_flags = 1'b0;
         end
         default: begin
            // MUL: nothing written at accept time
            w_wr_res   = 1'b0;
            w_wr_flags = 1'b0;
         end
      endcase
      w_z = (w_val == '0);
   end

   // One shift-add step: add A<<count when bit count of B is set
   always_comb begin
      w_addend   = r_b[r_cnt] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
      w_acc_next = r_acc + w_addend;
   end

   // Datapath registers: operand latch, multiplier state and result/flags
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_c      <= 1'b0;
         r_z      <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  if (i_sel == OpMul) begin
                     r_a   <= i_a;
                     r_b   <= i_b;
                     r_acc <= '0;
                     r_cnt <= '0;
                  end else begin
                     if (w_wr_res) r_result <= w_val;
                     if (w_wr_flags) begin
                        r_c <= w_c;
                        r_z <= w_z;
                     end
                     r_done <= 1'b1;
                  end
               end
            end
            StMul: begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + CW'(1);
               if (w_mul_last) begin
                  r_result <= w_acc_next[WIDTH-1:0];
                  r_c      <= |w_acc_next[2*WIDTH-1:WIDTH];
                  r_z      <= (w_acc_next[WIDTH-1:0] == '0);
                  r_done   <= 1'b1;
                  r_cnt    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_done   = r_done;
   assign o_result = r_result;
   assign o_c      = r_c;
   assign o_z      = r_z;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: WIDTH=8 and WIDTH=16 instances.
module tb_seq_alu;

   logic        clk;
   logic        rst_n;

   logic        s8_start, s8_cin;
   logic [3:0]  s8_sel;
   logic [7:0]  s8_a, s8_b;
   logic        d8_busy, d8_done, d8_c, d8_z;
   logic [7:0]  d8_result;

   logic        s16_start, s16_cin;
   logic [3:0]  s16_sel;
   logic [15:0] s16_a, s16_b;
   logic        d16_busy, d16_done, d16_c, d16_z;
   logic [15:0] d16_result;

   int checks = 0;
   int errors = 0;
   int lat;
   int hits;

   seq_alu #(.WIDTH(8)) u_dut8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(s8_start), .i_sel(s8_sel),
      .i_a(s8_a), .i_b(s8_b), .i_cin(s8_cin), .o_busy(d8_busy), .o_done(d8_done),
      .o_result(d8_result), .o_c(d8_c), .o_z(d8_z)
   );

   seq_alu #(.WIDTH(16)) u_dut16 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(s16_start), .i_sel(s16_sel),
      .i_a(s16_a), .i_b(s16_b), .i_cin(s16_cin), .o_busy(d16_busy),
      .o_done(d16_done), .o_result(d16_result), .o_c(d16_c), .o_z(d16_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] res, input logic c, input logic z,
                       input logic done);
      chk({tag, ".result"}, 32'(d8_result), 32'(res));
      chk({tag, ".c"}, 32'(d8_c), 32'(c));
      chk({tag, ".z"}, 32'(d8_z), 32'(z));
      chk({tag, ".done"}, 32'(d8_done), 32'(done));
   endtask

   task automatic chk16(input string tag, input logic [15:0] res, input logic c,
                        input logic z);
      chk({tag, ".result"}, 32'(d16_result), 32'(res));
      chk({tag, ".c"}, 32'(d16_c), 32'(c));
      chk({tag, ".z"}, 32'(d16_z), 32'(z));
      chk({tag, ".done"}, 32'(d16_done), 32'd1);
   endtask

   // Drive one START for a single edge; caller is positioned at a negedge
   task automatic go8(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                      input logic cin);
      s8_sel = sel; s8_a = a; s8_b = b; s8_cin = cin; s8_start = 1'b1;
      @(posedge clk); #1;
      s8_start = 1'b0;
   endtask

   task automatic issue8(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
      @(negedge clk);
      go8(sel, a, b, cin);
   endtask

   task automatic issue16(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                          input logic cin);
      @(negedge clk);
      s16_sel = sel; s16_a = a; s16_b = b; s16_cin = cin; s16_start = 1'b1;
      @(posedge clk); #1;
      s16_start = 1'b0;
   endtask

   // Count edges until DONE on the selected instance, bounded
   task automatic wait_done(input bit wide, output int n);
      n = 999;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if ((wide ? d16_done : d8_done) === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      s8_start = 0; s8_sel = 0; s8_a = 0; s8_b = 0; s8_cin = 0;
      s16_start = 0; s16_sel = 0; s16_a = 0; s16_b = 0; s16_cin = 0;
      #12;
      chk8("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      chk("reset.busy", 32'(d8_busy), 32'd0);

      // First START on the very first edge after release
      @(negedge clk);
      rst_n = 1'b1;
      go8(4'd0, 8'hFF, 8'h01, 1'b0);
      chk8("add_ff_01", 8'h00, 1'b1, 1'b1, 1'b1);
      @(posedge clk); #1;
      chk8("idle_hold", 8'h00, 1'b1, 1'b1, 1'b0);

      issue8(4'd3, 8'h10, 8'h10, 1'b1);
      chk8("subc", 8'hFF, 1'b1, 1'b0, 1'b1);
      issue8(4'd14, 8'h00, 8'h55, 1'b0);
      chk8("mov_55", 8'h55, 1'b1, 1'b0, 1'b1);
      issue8(4'd4, 8'h10, 8'h20, 1'b0);
      chk8("cmp", 8'h55, 1'b1, 1'b0, 1'b1);
      issue8(4'd14, 8'h00, 8'h00, 1'b0);
      chk8("mov_00", 8'h00, 1'b1, 1'b0, 1'b1);

      issue8(4'd5, 8'hF0, 8'h0F, 1'b0);
      chk8("and", 8'h00, 1'b0, 1'b1, 1'b1);
      issue8(4'd6, 8'hA0, 8'h05, 1'b0);
      chk8("or", 8'hA5, 1'b0, 1'b0, 1'b1);
      issue8(4'd7, 8'hFF, 8'h0F, 1'b0);
      chk8("xor", 8'hF0, 1'b0, 1'b0, 1'b1);
      issue8(4'd8, 8'h0F, 8'hF0, 1'b0);
      chk8("test", 8'hF0, 1'b0, 1'b1, 1'b1);
      issue8(4'd2, 8'h05, 8'h03, 1'b0);
      chk8("sub", 8'h02, 1'b0, 1'b0, 1'b1);
      issue8(4'd1, 8'h7F, 8'h7F, 1'b1);
      chk8("addc", 8'hFF, 1'b0, 1'b0, 1'b1);

      issue8(4'd9, 8'h81, 8'h00, 1'b0);
      chk8("lsl", 8'h02, 1'b1, 1'b0, 1'b1);
      issue8(4'd10, 8'h01, 8'h00, 1'b1);
      chk8("lsr", 8'h80, 1'b1, 1'b0, 1'b1);
      issue8(4'd11, 8'h81, 8'h00, 1'b0);
      chk8("rol", 8'h03, 1'b1, 1'b0, 1'b1);
      issue8(4'd12, 8'h02, 8'h00, 1'b1);
      chk8("ror", 8'h01, 1'b0, 1'b0, 1'b1);
      issue8(4'd13, 8'h80, 8'h00, 1'b1);
      chk8("asr", 8'hC0, 1'b0, 1'b0, 1'b1);

      // Multiplies: latency counted from the START edge
      issue8(4'd15, 8'h0F, 8'h11, 1'b0);
      chk("mul1.busy", 32'(d8_busy), 32'd1);
      chk("mul1.done_early", 32'(d8_done), 32'd0);
      wait_done(1'b0, lat);
      chk("mul1.latency", 32'(lat), 32'd8);
      chk8("mul1", 8'hFF, 1'b0, 1'b0, 1'b1);
      chk("mul1.busy_end", 32'(d8_busy), 32'd0);

      issue8(4'd15, 8'h10, 8'h10, 1'b0);
      wait_done(1'b0, lat);
      chk("mul2.latency", 32'(lat), 32'd8);
      chk8("mul2", 8'h00, 1'b1, 1'b1, 1'b1);

      // START while busy is ignored, operand changes do not leak in
      issue8(4'd15, 8'h03, 8'h05, 1'b0);
      @(negedge clk);
      s8_sel = 4'd0; s8_a = 8'h01; s8_b = 8'h01; s8_start = 1'b1;
      @(negedge clk);
      s8_a = 8'h77; s8_b = 8'hEE;
      @(negedge clk);
      s8_start = 1'b0;
      chk("mul3.busy_mid", 32'(d8_busy), 32'd1);
      chk("mul3.done_mid", 32'(d8_done), 32'd0);
      wait_done(1'b0, lat);
      chk("mul3.latency", 32'(lat), 32'd6);
      chk8("mul3", 8'h0F, 1'b0, 1'b0, 1'b1);
      // Back-to-back issue on the DONE cycle
      issue8(4'd0, 8'h20, 8'h22, 1'b0);
      chk8("b2b_add", 8'h42, 1'b0, 1'b0, 1'b1);

      // Reset during MUL cycle 3
      issue8(4'd15, 8'hFF, 8'hFF, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3;
      chk("rstmul.busy_before", 32'(d8_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk8("rstmul", 8'h00, 1'b0, 1'b0, 1'b0);
      chk("rstmul.busy", 32'(d8_busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (d8_done !== 1'b0 || d8_busy !== 1'b0) hits++;
      end
      chk("rstmul.no_done_after", 32'(hits), 32'd0);
      chk("rstmul.result_after", 32'(d8_result), 32'd0);

      // WIDTH=16 instance
      issue16(4'd1, 16'hFFFF, 16'h0000, 1'b1);
      chk16("w16_addc", 16'h0000, 1'b1, 1'b1);
      issue16(4'd13, 16'h8001, 16'h0000, 1'b0);
      chk16("w16_asr", 16'hC000, 1'b1, 1'b0);
      issue16(4'd15, 16'h0100, 16'h0100, 1'b0);
      wait_done(1'b1, lat);
      chk("w16_mul.latency", 32'(lat), 32'd16);
      chk16("w16_mul", 16'h0000, 1'b1, 1'b1);
      issue16(4'd15, 16'h1234, 16'h0003, 1'b0);
      wait_done(1'b1, lat);
      chk16("w16_mul2", 16'h369C, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width; legal values 4..32.
REQ-002 Port CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port RST_N  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port START  input  1  SHALL request an operation; sampled only in IDLE.
REQ-005 Port SEL  input  4  SHALL select the opcode per REQ-012..REQ-016.
REQ-006 Ports A, B  input  WIDTH  SHALL be the operands, latched when START is accepted.
REQ-007 Port CIN  input  1  SHALL be the carry-in, latched with A and B.
REQ-008 Port BUSY  output  1  SHALL be high while a multi-cycle operation is in progress.
REQ-009 Port DONE  output  1  SHALL pulse high for exactly one cycle when RESULT/C/Z are updated.
REQ-010 Port RESULT  output  WIDTH  SHALL be the registered result.
REQ-011 Ports C, Z  output  1 each  SHALL be the registered carry/borrow and zero flags.

Function
REQ-012 Opcodes 0-14 SHALL be single-cycle: START accepted in IDLE -> RESULT/C/Z updated and DONE high on the next rising edge; BUSY stays low.
REQ-013 Arithmetic SHALL use a WIDTH+1-bit intermediate: 0 ADD A+B; 1 ADDC A+B+CIN; 2 SUB A-B; 3 SUBC A-B-CIN; 4 CMP A-B; C = bit WIDTH (carry for add, borrow for sub).
REQ-014 Logic: 5 AND, 6 OR, 7 XOR, 8 TEST (AND); C SHALL be cleared.
REQ-015 Shifts (N=WIDTH): 9 LSL {A[N-2:0],CIN}, C=A[N-1]; 10 LSR {CIN,A[N-1:1]}, C=A[0]; 11 ROL {A[N-2:0],A[N-1]}, C=A[N-1]; 12 ROR {A[0],A[N-1:1]}, C=A[0]; 13 ASR {A[N-1],A[N-1:1]}, C=A[0].
REQ-016 Opcode 15 MUL SHALL compute unsigned A*B by shift-add, one bit per cycle, WIDTH iterations.
REQ-017 MUL: RESULT = low WIDTH bits of product; C = 1 iff high WIDTH bits nonzero; Z per REQ-019 on low bits.
REQ-018 Opcode 14 MOV: RESULT=B; C and Z SHALL hold previous values.
REQ-019 Z SHALL be 1 iff the WIDTH-bit computed value is zero, for all opcodes except MOV.
REQ-020 CMP and TEST SHALL update C and Z only; RESULT SHALL hold its previous value.
REQ-021 FSM states SHALL be IDLE and MUL: IDLE --START&SEL==15--> MUL (BUSY=1, iteration count=0); MUL --count==WIDTH-1--> IDLE with DONE pulse and RESULT/C/Z written on that edge.
REQ-022 MUL latency SHALL be exactly WIDTH cycles from the START edge to the DONE edge; BUSY high for those WIDTH cycles.
REQ-023 START while BUSY SHALL be ignored; latched operands and in-flight MUL unaffected.
REQ-024 START on the cycle DONE is high (FSM back in IDLE) SHALL be accepted normally (back-to-back issue).
REQ-025 Outputs SHALL hold between operations; DONE low when no update occurs.
REQ-026 Changes on A/B/CIN/SEL after acceptance SHALL NOT affect the in-flight operation.

Reset
REQ-027 RST_N low SHALL immediately force state IDLE, BUSY=0, DONE=0, RESULT=0, C=0, Z=0, and clear the multiplier accumulator and counter.
REQ-028 Reset asserted mid-MUL SHALL abort it; no DONE pulse after release.
REQ-029 First START SHALL be accepted on the first rising edge after RST_N deasserts.

Verification
REQ-030 WIDTH=8, reset during MUL cycle 3 -> BUSY=0, DONE=0, RESULT=0x00, C=0, Z=0 immediately; no later DONE.
REQ-031 WIDTH=8, ADD A=0xFF B=0x01 -> next edge RESULT=0x00, C=1, Z=1, DONE one cycle; then SUBC A=0x10 B=0x10 CIN=1 -> RESULT=0xFF, C=1, Z=0.
REQ-032 WIDTH=8, RESULT=0x55, CMP A=0x10 B=0x20 -> RESULT stays 0x55, C=1, Z=0; then MOV B=0x00 -> RESULT=0x00, C=1, Z=0 held.
REQ-033 WIDTH=8, MUL 0x0F*0x11 -> DONE 8 cycles after START, RESULT=0xFF, C=0, Z=0; MUL 0x10*0x10 -> RESULT=0x00, C=1, Z=1.
REQ-034 WIDTH=8, START ADD during MUL 0x03*0x05 -> ignored, MUL gives RESULT=0x0F; ADD issued on DONE cycle -> completes next edge.
REQ-035 WIDTH=16, ADDC A=0xFFFF B=0x0000 CIN=1 -> RESULT=0x0000, C=1, Z=1; ASR A=0x8001 -> RESULT=0xC000, C=1.
